hazard_control_unit: RTL and testbench
======================================

// Module: hazard_control_unit
// PURPOSE
//   Pipeline sequencer for the 5-stage core; companion to Forwarding_Unit. Decides per cycle which
//   pipeline registers advance, stall or flush: load-use stalls, taken-branch flushes, HI/LO
//   interlock on the multi-cycle mult/div unit, and full freeze while data memory is not ready.
//   Also keeps a saturating stall-cycle counter and a sticky memory-timeout flag.
// PARAMETERS
//   MULT_LAT     4    cycles from mult issue in EX until HI/LO valid
//   DIV_LAT      32   cycles from div issue in EX until HI/LO valid
//   MEM_TIMEOUT  255  consecutive not-ready cycles before MemTimeout sets
//   CNT_W        16   width of StallCount
// PORTS
//   clk            in   1      clock, rising edge
//   rst_n          in   1      asynchronous active-low reset
//   IdExMemRead    in   1      EX-stage instruction is a load
//   IdExRt         in   5      EX-stage load destination
//   IfIdRs         in   5      ID-stage source rs
//   IfIdRt         in   5      ID-stage source rt
//   IfIdUsesRt     in   1      ID instruction actually reads rt
//   IfIdHiLoUse    in   1      ID instr is mfhi/mflo/mthi/mtlo/mult/div
//   ExMulDivStart  in   1      EX-stage instr is mult/div
//   ExIsDiv        in   1      1 = div, 0 = mult (valid with ExMulDivStart)
//   ExBranchTaken  in   1      branch/jump resolved taken in EX
//   ExMemMemAccess in   1      MEM-stage load/store
//   DmemReady      in   1      data memory completes access this cycle
//   PcWrite        out  1      PC update enable
//   IfIdWrite      out  1      IF/ID register enable
//   IdExWrite      out  1      ID/EX register enable
//   ExMemWrite     out  1      EX/MEM register enable
//   IfIdFlush      out  1      zero IF/ID
//   IdExBubble     out  1      load NOP into ID/EX
//   MemWbBubble    out  1      load NOP into MEM/WB
//   MulDivBusy     out  1      HI/LO result pending
//   StallCount     out  CNT_W  saturating count of cycles with PcWrite=0
//   MemTimeout     out  1      sticky: memory wait exceeded MEM_TIMEOUT
// BEHAVIOUR
//   Reset (rst_n=0, async): state RUN, MdCnt=0, WaitCnt=0, StallCount=0, MemTimeout=0.
//     Outputs during reset: all *Write=0, IfIdFlush=IdExBubble=MemWbBubble=1, MulDivBusy=0.
//   Control outputs combinational from registered state + inputs (0-cycle latency).
//   Condition priority (highest first), evaluated each cycle:
//   1 FREEZE: ExMemMemAccess & !DmemReady -> PcWrite=IfIdWrite=IdExWrite=ExMemWrite=0,
//     MemWbBubble=1; no flush/bubble elsewhere; state MEM_WAIT next.
//   2 FLUSH: ExBranchTaken -> IfIdFlush=1, IdExBubble=1, all *Write=1 (overrides any stall).
//   3 STALL: load-use = IdExMemRead & IdExRt!=0 & (IdExRt==IfIdRs | IfIdUsesRt & IdExRt==IfIdRt),
//     or HiLo = IfIdHiLoUse & (MulDivBusy | ExMulDivStart) -> PcWrite=IfIdWrite=0, IdExBubble=1,
//     IdExWrite=ExMemWrite=1.
//   4 else all *Write=1, no flush/bubble.
//   FSM: RUN -> MEM_WAIT on FREEZE; MEM_WAIT -> RUN when DmemReady=1 (that cycle not frozen).
//     WaitCnt increments each MEM_WAIT cycle, clears in RUN; WaitCnt==MEM_TIMEOUT sets MemTimeout
//     (cleared only by reset); WaitCnt saturates.
//   Mult/div: MdCnt loads MULT_LAT or DIV_LAT when ExMulDivStart & ExMemWrite; else decrements
//     when nonzero, including during FREEZE. MulDivBusy = (MdCnt!=0). Start when MdCnt==1: reload.
//   StallCount +1 each cycle PcWrite=0 out of reset; holds at 2^CNT_W-1.
//   Register 0 never causes load-use stall.
// STRUCTURE
//   Shared pkg (hazard_pkg): state encoding RUN/MEM_WAIT, default latencies.
//   One sub-module: muldiv_busy_tracker (MdCnt load/decrement, MulDivBusy). Rest flat.
// TESTING
//   Load-use: IdExMemRead=1, IdExRt=5, IfIdRs=5 -> 1 cycle PcWrite=0, IdExBubble=1; IdExRt=0 -> none.
//   Branch+stall: ExBranchTaken=1 with load-use true -> IfIdFlush=1, IdExBubble=1, PcWrite=1.
//   Mult: ExMulDivStart=1, ExIsDiv=0, then IfIdHiLoUse=1 -> stall 4 cycles, PcWrite=1 on 5th.
//   Freeze: DmemReady=0 for 3 cycles -> all *Write=0, MemWbBubble=1 for 3 cycles; StallCount=3.
//   Timeout: DmemReady=0 for 256 cycles -> MemTimeout=1, stays 1 after DmemReady=1 until rst_n=0.
//   Async reset mid-div (MdCnt=20): rst_n=0 -> MulDivBusy=0, StallCount=0 without clock edge.

Source files
------------

// File: rtl/hazard_pkg.sv
// Shared definitions for the pipeline hazard sequencer: FSM encoding and default latencies.
package hazard_pkg;

  typedef enum logic {
    RUN      = 1'b0,
    MEM_WAIT = 1'b1
  } hz_state_e;

  localparam int DEF_MULT_LAT    = 4;
  localparam int DEF_DIV_LAT     = 32;
  localparam int DEF_MEM_TIMEOUT = 255;
  localparam int DEF_CNT_W       = 16;

endpackage

// File: rtl/muldiv_busy_tracker.sv
// Counts down the remaining latency of the multi-cycle mult/div unit; busy while HI/LO is pending.
module muldiv_busy_tracker
  import hazard_pkg::*;
#(
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic start_i,
  input  logic is_div_i,
  input  logic advance_i,
  output logic busy_o
);

  localparam int MAX_LAT = (DIV_LAT > MULT_LAT) ? DIV_LAT : MULT_LAT;
  localparam int MD_W    = $clog2(MAX_LAT + 1);

  logic [MD_W-1:0] md_cnt_q, md_cnt_d;

  // A start only counts when the EX/MEM register actually captures it; a start
  // arriving on the last pending cycle simply reloads.
  always_comb begin
    md_cnt_d = md_cnt_q;
    if (start_i && advance_i) begin
      md_cnt_d = is_div_i ? MD_W'(DIV_LAT) : MD_W'(MULT_LAT);
    end else if (md_cnt_q != '0) begin
      md_cnt_d = md_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt_q <= '0;
    end else begin
      md_cnt_q <= md_cnt_d;
    end
  end

  assign busy_o = (md_cnt_q != '0);

endmodule

// File: rtl/hazard_control_unit.sv
// Per-cycle advance/stall/flush decisions for the 5-stage pipeline, plus stall
// statistics and a sticky data-memory timeout flag.
module hazard_control_unit
  import hazard_pkg::*;
#(
  parameter int MULT_LAT    = DEF_MULT_LAT,
  parameter int DIV_LAT     = DEF_DIV_LAT,
  parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
  parameter int CNT_W       = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             IdExMemRead,
  input  logic [4:0]       IdExRt,
  input  logic [4:0]       IfIdRs,
  input  logic [4:0]       IfIdRt,
  input  logic             IfIdUsesRt,
  input  logic             IfIdHiLoUse,
  input  logic             ExMulDivStart,
  input  logic             ExIsDiv,
  input  logic             ExBranchTaken,
  input  logic             ExMemMemAccess,
  input  logic             DmemReady,
  output logic             PcWrite,
  output logic             IfIdWrite,
  output logic             IdExWrite,
  output logic             ExMemWrite,
  output logic             IfIdFlush,
  output logic             IdExBubble,
  output logic             MemWbBubble,
  output logic             MulDivBusy,
  output logic [CNT_W-1:0] StallCount,
  output logic             MemTimeout
);

  localparam int WAIT_W = $clog2(MEM_TIMEOUT + 1);

  hz_state_e         state_q, state_d;
  logic [WAIT_W-1:0] wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  stall_cnt_q, stall_cnt_d;
  logic              mem_timeout_q, mem_timeout_d;
  logic              freeze, load_use, hilo_hazard;

  muldiv_busy_tracker #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT)
  ) u_muldiv (
    .clk       (clk),
    .rst_n     (rst_n),
    .start_i   (ExMulDivStart),
    .is_div_i  (ExIsDiv),
    .advance_i (ExMemWrite),
    .busy_o    (MulDivBusy)
  );

  assign freeze      = ExMemMemAccess && !DmemReady;
  assign load_use    = IdExMemRead && (IdExRt != 5'd0) &&
                       ((IdExRt == IfIdRs) || (IfIdUsesRt && (IdExRt == IfIdRt)));
  assign hilo_hazard = IfIdHiLoUse && (MulDivBusy || ExMulDivStart);

  // Pipeline control: freeze beats flush beats stall; reset holds everything flushed.
  always_comb begin
    PcWrite     = 1'b1;
    IfIdWrite   = 1'b1;
    IdExWrite   = 1'b1;
    ExMemWrite  = 1'b1;
    IfIdFlush   = 1'b0;
    IdExBubble  = 1'b0;
    MemWbBubble = 1'b0;
    if (!rst_n) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExWrite   = 1'b0;
      ExMemWrite  = 1'b0;
      IfIdFlush   = 1'b1;
      IdExBubble  = 1'b1;
      MemWbBubble = 1'b1;
    end else if (freeze) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExWrite   = 1'b0;
      ExMemWrite  = 1'b0;
      MemWbBubble = 1'b1;
    end else if (ExBranchTaken) begin
      IfIdFlush   = 1'b1;
      IdExBubble  = 1'b1;
    end else if (load_use || hilo_hazard) begin
      PcWrite     = 1'b0;
      IfIdWrite   = 1'b0;
      IdExBubble  = 1'b1;
    end
  end

  always_comb begin
    state_d       = state_q;
    wait_cnt_d    = '0;
    mem_timeout_d = mem_timeout_q;
    stall_cnt_d   = stall_cnt_q;
    if (freeze) begin
      state_d = MEM_WAIT;
    end else if ((state_q == MEM_WAIT) && DmemReady) begin
      state_d = RUN;
    end
    if (state_q == MEM_WAIT) begin
      wait_cnt_d = (wait_cnt_q == '1) ? wait_cnt_q : wait_cnt_q + 1'b1;
      if (wait_cnt_d == WAIT_W'(MEM_TIMEOUT)) begin
        mem_timeout_d = 1'b1;
      end
    end
    if (!PcWrite && (stall_cnt_q != '1)) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= RUN;
      wait_cnt_q    <= '0;
      stall_cnt_q   <= '0;
      mem_timeout_q <= 1'b0;
    end else begin
      state_q       <= state_d;
      wait_cnt_q    <= wait_cnt_d;
      stall_cnt_q   <= stall_cnt_d;
      mem_timeout_q <= mem_timeout_d;
    end
  end

  assign StallCount = stall_cnt_q;
  assign MemTimeout = mem_timeout_q;

endmodule

// File: tb/tb_hazard_control_unit.sv
// Directed-vector bench for hazard_control_unit with hand-computed expectations.
module tb_hazard_control_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        IdExMemRead, IfIdUsesRt, IfIdHiLoUse, ExMulDivStart, ExIsDiv;
  logic        ExBranchTaken, ExMemMemAccess, DmemReady;
  logic [4:0]  IdExRt, IfIdRs, IfIdRt;
  logic        PcWrite, IfIdWrite, IdExWrite, ExMemWrite;
  logic        IfIdFlush, IdExBubble, MemWbBubble, MulDivBusy, MemTimeout;
  logic [15:0] StallCount;
  logic [3:0]  wr_v;
  logic [2:0]  fl_v;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  hazard_control_unit dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .IdExMemRead    (IdExMemRead),
    .IdExRt         (IdExRt),
    .IfIdRs         (IfIdRs),
    .IfIdRt         (IfIdRt),
    .IfIdUsesRt     (IfIdUsesRt),
    .IfIdHiLoUse    (IfIdHiLoUse),
    .ExMulDivStart  (ExMulDivStart),
    .ExIsDiv        (ExIsDiv),
    .ExBranchTaken  (ExBranchTaken),
    .ExMemMemAccess (ExMemMemAccess),
    .DmemReady      (DmemReady),
    .PcWrite        (PcWrite),
    .IfIdWrite      (IfIdWrite),
    .IdExWrite      (IdExWrite),
    .ExMemWrite     (ExMemWrite),
    .IfIdFlush      (IfIdFlush),
    .IdExBubble     (IdExBubble),
    .MemWbBubble    (MemWbBubble),
    .MulDivBusy     (MulDivBusy),
    .StallCount     (StallCount),
    .MemTimeout     (MemTimeout)
  );

  // {PcWrite, IfIdWrite, IdExWrite, ExMemWrite} and {IfIdFlush, IdExBubble, MemWbBubble}
  assign wr_v = {PcWrite, IfIdWrite, IdExWrite, ExMemWrite};
  assign fl_v = {IfIdFlush, IdExBubble, MemWbBubble};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    IdExMemRead    = 1'b0;
    IdExRt         = 5'd0;
    IfIdRs         = 5'd0;
    IfIdRt         = 5'd0;
    IfIdUsesRt     = 1'b0;
    IfIdHiLoUse    = 1'b0;
    ExMulDivStart  = 1'b0;
    ExIsDiv        = 1'b0;
    ExBranchTaken  = 1'b0;
    ExMemMemAccess = 1'b0;
    DmemReady      = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    idle();
    #2;
    check("rst_writes", wr_v, 4'b0000);
    check("rst_flush", fl_v, 3'b111);
    check("rst_busy", MulDivBusy, 1'b0);
    check("rst_stallcnt", StallCount, 16'd0);
    check("rst_timeout", MemTimeout, 1'b0);
    #10;
    rst_n = 1'b1;
    tick();

    #1;
    check("idle_writes", wr_v, 4'b1111);
    check("idle_flush", fl_v, 3'b000);

    // Load-use on rs
    IdExMemRead = 1'b1; IdExRt = 5'd5; IfIdRs = 5'd5;
    #1;
    check("lu_rs_writes", wr_v, 4'b0011);
    check("lu_rs_flush", fl_v, 3'b010);
    tick();
    idle();
    #1;
    check("lu_after_writes", wr_v, 4'b1111);
    check("lu_stallcnt", StallCount, 16'd1);

    // Register 0 never stalls
    IdExMemRead = 1'b1; IdExRt = 5'd0; IfIdRs = 5'd0;
    #1;
    check("lu_r0_writes", wr_v, 4'b1111);

    // rt match only matters when rt is actually read
    IdExRt = 5'd7; IfIdRs = 5'd3; IfIdRt = 5'd7; IfIdUsesRt = 1'b1;
    #1;
    check("lu_rt_writes", wr_v, 4'b0011);
    IfIdUsesRt = 1'b0;
    #1;
    check("lu_rt_unused", wr_v, 4'b1111);

    // Branch overrides load-use stall
    IfIdRs = 5'd7; ExBranchTaken = 1'b1;
    #1;
    check("br_writes", wr_v, 4'b1111);
    check("br_flush", fl_v, 3'b110);

    // Freeze overrides branch
    ExMemMemAccess = 1'b1; DmemReady = 1'b0;
    #1;
    check("frz_br_writes", wr_v, 4'b0000);
    check("frz_br_flush", fl_v, 3'b001);
    idle();
    tick();

    // Mult: start in EX together with HI/LO user in ID stalls immediately
    ExMulDivStart = 1'b1; ExIsDiv = 1'b0; IfIdHiLoUse = 1'b1;
    #1;
    check("md_start_hilo", PcWrite, 1'b0);
    IfIdHiLoUse = 1'b0;
    #1;
    check("md_start_writes", wr_v, 4'b1111);
    tick();
    idle();
    IfIdHiLoUse = 1'b1;
    for (int i = 0; i < 4; i++) begin
      #1;
      check($sformatf("mul_stall%0d", i), {PcWrite, MulDivBusy}, 2'b01);
      tick();
    end
    check("mul_release", {PcWrite, MulDivBusy}, 2'b10);
    check("mul_stallcnt", StallCount, 16'd5);
    idle();

    // Freeze for three cycles from a fresh reset
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    tick();
    ExMemMemAccess = 1'b1; DmemReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      #1;
      check($sformatf("frz_writes%0d", i), wr_v, 4'b0000);
      check($sformatf("frz_flush%0d", i), fl_v, 3'b001);
      tick();
    end
    DmemReady = 1'b1;
    #1;
    check("frz_done_writes", wr_v, 4'b1111);
    check("frz_stallcnt", StallCount, 16'd3);
    tick();

    // Memory timeout after 256 consecutive frozen cycles
    DmemReady = 1'b0;
    for (int i = 0; i < 255; i++) tick();
    check("to_before", MemTimeout, 1'b0);
    tick();
    check("to_set", MemTimeout, 1'b1);
    DmemReady = 1'b1;
    tick();
    ExMemMemAccess = 1'b0;
    tick();
    tick();
    check("to_sticky", MemTimeout, 1'b1);
    check("to_stallcnt", StallCount, 16'd259);

    // Divide in flight, then asynchronous reset between edges
    ExMulDivStart = 1'b1; ExIsDiv = 1'b1;
    tick();
    idle();
    IfIdHiLoUse = 1'b1;
    for (int i = 0; i < 12; i++) tick();
    check("div_busy", MulDivBusy, 1'b1);
    check("div_stallcnt", StallCount, 16'd271);
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_busy", MulDivBusy, 1'b0);
    check("arst_stallcnt", StallCount, 16'd0);
    check("arst_timeout", MemTimeout, 1'b0);
    check("arst_writes", wr_v, 4'b0000);
    check("arst_flush", fl_v, 3'b111);
    #3;
    rst_n = 1'b1;
    idle();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
